// File: rtl/wb_regfile_stage_pkg.sv
// Shared definitions for the write-back stage: datapath width, bank
// geometry, stack-pointer placement and the bank-select encoding.
package wb_regfile_stage_pkg;

    localparam int DATA_W     = 16;
    localparam int NUM_GPR    = 8;
    localparam int NUM_PRIV   = 4;
    localparam int GPR_IDX_W  = 3;
    localparam int PRIV_IDX_W = 2;
    localparam int SP_IDX     = 0;

    localparam logic [DATA_W-1:0] SP_RESET = 16'h0FFF;

    // Value of dest_or_private_i selecting each bank
    localparam logic BANK_GPR  = 1'b0;
    localparam logic BANK_PRIV = 1'b1;

    // Per-entry reset images, entry 0 in the least significant slice
    localparam logic [NUM_GPR*DATA_W-1:0]  GPR_RESET  = '0;
    localparam logic [NUM_PRIV*DATA_W-1:0] PRIV_RESET =
        {{((NUM_PRIV-1)*DATA_W){1'b0}}, SP_RESET} << (SP_IDX*DATA_W);

endpackage

// File: rtl/wb_regfile_stage_reg_bank.sv
// Register bank with asynchronous reset to a per-entry image, one write
// port and NUM_RD combinational write-first read ports.
module reg_bank #(
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3,
    parameter int DATA_W = 16,
    parameter int NUM_RD = 2,
    parameter logic [DEPTH*DATA_W-1:0] RESET_VALS = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [IDX_W-1:0]         wrIdx,
    input  logic [DATA_W-1:0]        wrData,
    input  logic [NUM_RD*IDX_W-1:0]  rdIdx,
    output logic [NUM_RD*DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage: reload the reset image on rst, otherwise commit the single write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VALS[i*DATA_W +: DATA_W];
            end
        end else if (we) begin
            mem[wrIdx] <= wrData;
        end
    end

    // Each read port returns the in-flight write when it targets the same entry
    for (genvar g = 0; g < NUM_RD; g++) begin : gRead
        logic [IDX_W-1:0] idx;
        assign idx = rdIdx[g*IDX_W +: IDX_W];
        assign rdData[g*DATA_W +: DATA_W] = (we && (idx == wrIdx)) ? wrData : mem[idx];
    end

endmodule

// File: rtl/wb_regfile_stage.sv
// Write-back stage: selects the result, commits it to the GPR or private
// bank, offers bypassing reads and forwarding info, and counts retirements.
module wb_regfile_stage
    import wb_regfile_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write_i,
    input  logic              mem_or_reg_i,
    input  logic              dest_or_private_i,
    input  logic              bubble_i,
    input  logic [3:0]        dest_addr_i,
    input  logic [DATA_W-1:0] data_res_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic [2:0]        rd_addr_a_i,
    input  logic [2:0]        rd_addr_b_i,
    output logic [DATA_W-1:0] rd_data_a_o,
    output logic [DATA_W-1:0] rd_data_b_o,
    input  logic [1:0]        priv_rd_addr_i,
    output logic [DATA_W-1:0] priv_rd_data_o,
    output logic              wb_valid_o,
    output logic              wb_priv_o,
    output logic [3:0]        wb_addr_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [DATA_W-1:0] retired_o,
    output logic              addr_err_o
);

    logic              writeActive;
    logic              legal;
    logic              we;
    logic              gprWe;
    logic              privWe;
    logic [DATA_W-1:0] wbData;
    logic [DATA_W-1:0] retiredCount;
    logic              addrErr;

    // The private bank only decodes the low two address bits, so anything above must be zero
    assign wbData      = mem_or_reg_i ? mem_data_i : data_res_i;
    assign writeActive = reg_write_i & ~bubble_i;
    assign legal       = (dest_or_private_i == BANK_PRIV) ? (dest_addr_i[3:2] == 2'b00)
                                                          : ~dest_addr_i[3];
    assign we          = writeActive & legal & ~rst;
    assign gprWe       = we & (dest_or_private_i == BANK_GPR);
    assign privWe      = we & (dest_or_private_i == BANK_PRIV);

    assign wb_valid_o = we;
    assign wb_priv_o  = dest_or_private_i;
    assign wb_addr_o  = dest_addr_i;
    assign wb_data_o  = wbData;
    assign retired_o  = retiredCount;
    assign addr_err_o = addrErr;

    reg_bank #(
        .DEPTH      (NUM_GPR),
        .IDX_W      (GPR_IDX_W),
        .DATA_W     (DATA_W),
        .NUM_RD     (2),
        .RESET_VALS (GPR_RESET)
    ) gprBank (
        .clk    (clk),
        .rst    (rst),
        .we     (gprWe),
        .wrIdx  (dest_addr_i[GPR_IDX_W-1:0]),
        .wrData (wbData),
        .rdIdx  ({rd_addr_b_i, rd_addr_a_i}),
        .rdData ({rd_data_b_o, rd_data_a_o})
    );

    reg_bank #(
        .DEPTH      (NUM_PRIV),
        .IDX_W      (PRIV_IDX_W),
        .DATA_W     (DATA_W),
        .NUM_RD     (1),
        .RESET_VALS (PRIV_RESET)
    ) privBank (
        .clk    (clk),
        .rst    (rst),
        .we     (privWe),
        .wrIdx  (dest_addr_i[PRIV_IDX_W-1:0]),
        .wrData (wbData),
        .rdIdx  (priv_rd_addr_i),
        .rdData (priv_rd_data_o)
    );

    // Every non-bubble slot retires, including ones whose write was dropped; wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retiredCount <= '0;
        end else if (!bubble_i) begin
            retiredCount <= retiredCount + 16'd1;
        end
    end

    // Sticky flag for a write that targeted an address outside its bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addrErr <= 1'b0;
        end else if (writeActive && !legal) begin
            addrErr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Self-checking bench for wb_regfile_stage: a reference model of both banks,
// the retire counter and the error flag, with per-slot expectations queued.
module tb_wb_regfile_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reg_write_i = 1'b0;
    logic        mem_or_reg_i = 1'b0;
    logic        dest_or_private_i = 1'b0;
    logic        bubble_i = 1'b1;
    logic [3:0]  dest_addr_i = 4'h0;
    logic [15:0] data_res_i = 16'h0;
    logic [15:0] mem_data_i = 16'h0;
    logic [2:0]  rd_addr_a_i = 3'd0;
    logic [2:0]  rd_addr_b_i = 3'd0;
    logic [15:0] rd_data_a_o;
    logic [15:0] rd_data_b_o;
    logic [1:0]  priv_rd_addr_i = 2'd0;
    logic [15:0] priv_rd_data_o;
    logic        wb_valid_o;
    logic        wb_priv_o;
    logic [3:0]  wb_addr_o;
    logic [15:0] wb_data_o;
    logic [15:0] retired_o;
    logic        addr_err_o;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] retired;
        logic        err;
    } exp_t;

    exp_t        expQ[$];
    logic [15:0] gprModel [8];
    logic [15:0] privModel [4];
    logic [15:0] retModel;
    logic        errModel;

    wb_regfile_stage dut (
        .clk               (clk),
        .rst               (rst),
        .reg_write_i       (reg_write_i),
        .mem_or_reg_i      (mem_or_reg_i),
        .dest_or_private_i (dest_or_private_i),
        .bubble_i          (bubble_i),
        .dest_addr_i       (dest_addr_i),
        .data_res_i        (data_res_i),
        .mem_data_i        (mem_data_i),
        .rd_addr_a_i       (rd_addr_a_i),
        .rd_addr_b_i       (rd_addr_b_i),
        .rd_data_a_o       (rd_data_a_o),
        .rd_data_b_o       (rd_data_b_o),
        .priv_rd_addr_i    (priv_rd_addr_i),
        .priv_rd_data_o    (priv_rd_data_o),
        .wb_valid_o        (wb_valid_o),
        .wb_priv_o         (wb_priv_o),
        .wb_addr_o         (wb_addr_o),
        .wb_data_o         (wb_data_o),
        .retired_o         (retired_o),
        .addr_err_o        (addr_err_o)
    );

    // Free-running core clock
    always #5 clk = ~clk;

    // Watchdog so the run always ends even if the clock stalls
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    // Put the reference model into its post-reset state
    task automatic reset_model();
        for (int i = 0; i < 8; i++) gprModel[i] = 16'h0;
        for (int i = 0; i < 4; i++) privModel[i] = 16'h0;
        privModel[0] = 16'h0FFF;
        retModel = 16'h0;
        errModel = 1'b0;
        expQ.delete();
    endtask

    // Present one MEM/WB slot at negedge and queue the state expected after the next posedge
    task automatic drive_slot(input logic rw, input logic mor, input logic priv, input logic bub,
                              input logic [3:0] dest, input logic [15:0] res, input logic [15:0] mem);
        logic [15:0] d;
        logic        lg;
        exp_t        e;
        @(negedge clk);
        reg_write_i       = rw;
        mem_or_reg_i      = mor;
        dest_or_private_i = priv;
        bubble_i          = bub;
        dest_addr_i       = dest;
        data_res_i        = res;
        mem_data_i        = mem;
        d  = mor ? mem : res;
        lg = priv ? (dest[3:2] == 2'b00) : (dest[3] == 1'b0);
        if (rw && !bub) begin
            if (!lg) errModel = 1'b1;
            else if (priv) privModel[dest[1:0]] = d;
            else gprModel[dest[2:0]] = d;
        end
        if (!bub) retModel = retModel + 16'd1;
        e.retired = retModel;
        e.err     = errModel;
        expQ.push_back(e);
    endtask

    // Park the upstream buffer on an idle bubble
    task automatic idle();
        @(negedge clk);
        reg_write_i = 1'b0;
        bubble_i    = 1'b1;
    endtask

    // Reset state, and no write while rst is held even with a legal request
    task automatic test_reset();
        reset_model();
        reg_write_i = 1'b1; bubble_i = 1'b0; dest_addr_i = 4'h3; data_res_i = 16'hDEAD;
        rd_addr_a_i = 3'd3; priv_rd_addr_i = 2'd0;
        #1 rst = 1'b1;
        #1;
        total++; if (wb_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_wb_valid got=%b want=0", wb_valid_o); end
        total++; if (retired_o !== 16'h0) begin bad++; $display("[TB] FAIL reset_retired got=%h want=0000", retired_o); end
        total++; if (addr_err_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b want=0", addr_err_o); end
        total++; if (priv_rd_data_o !== privModel[0]) begin bad++; $display("[TB] FAIL reset_sp got=%h want=%h", priv_rd_data_o, privModel[0]); end
        @(posedge clk);
        @(negedge clk);
        reg_write_i = 1'b0; bubble_i = 1'b1;
        rst = 1'b0;
        #1;
        total++; if (rd_data_a_o !== gprModel[3]) begin bad++; $display("[TB] FAIL reset_no_write got=%h want=%h", rd_data_a_o, gprModel[3]); end
    endtask

    // Plain ALU write, then read it back from storage
    task automatic test_write();
        exp_t e;
        drive_slot(1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 16'hBEEF, 16'h0000);
        #1;
        total++; if (wb_valid_o !== 1'b1 || wb_data_o !== 16'hBEEF) begin bad++; $display("[TB] FAIL write_fwd got=%b/%h want=1/beef", wb_valid_o, wb_data_o); end
        @(posedge clk); #1;
        e = expQ.pop_front();
        total++; if (retired_o !== e.retired) begin bad++; $display("[TB] FAIL write_retired got=%h want=%h", retired_o, e.retired); end
        idle();
        rd_addr_a_i = 3'd3;
        #1;
        total++; if (rd_data_a_o !== gprModel[3]) begin bad++; $display("[TB] FAIL write_readback got=%h want=%h", rd_data_a_o, gprModel[3]); end
    endtask

    // Memory-data select and write-first bypass on both ports at once
    task automatic test_bypass();
        exp_t e;
        drive_slot(1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 16'hAAAA, 16'h1234);
        rd_addr_a_i = 3'd5; rd_addr_b_i = 3'd5;
        #1;
        total++; if (rd_data_a_o !== 16'h1234) begin bad++; $display("[TB] FAIL bypass_a got=%h want=1234", rd_data_a_o); end
        total++; if (rd_data_b_o !== 16'h1234) begin bad++; $display("[TB] FAIL bypass_b got=%h want=1234", rd_data_b_o); end
        total++; if (wb_valid_o !== 1'b1 || wb_addr_o !== 4'h5 || wb_priv_o !== 1'b0) begin bad++; $display("[TB] FAIL bypass_fwd got=%b/%h/%b want=1/5/0", wb_valid_o, wb_addr_o, wb_priv_o); end
        @(posedge clk); #1;
        e = expQ.pop_front();
        total++; if (retired_o !== e.retired) begin bad++; $display("[TB] FAIL bypass_retired got=%h want=%h", retired_o, e.retired); end
        idle();
        rd_addr_a_i = 3'd3;
        #1;
        total++; if (rd_data_a_o !== gprModel[3] || rd_data_b_o !== gprModel[5]) begin bad++; $display("[TB] FAIL bypass_store got=%h/%h want=%h/%h", rd_data_a_o, rd_data_b_o, gprModel[3], gprModel[5]); end
    endtask

    // Bubble slot carrying a write request must be inert
    task automatic test_bubble();
        exp_t e;
        drive_slot(1'b1, 1'b0, 1'b0, 1'b1, 4'h2, 16'hFFFF, 16'h0000);
        rd_addr_a_i = 3'd2;
        #1;
        total++; if (wb_valid_o !== 1'b0 || rd_data_a_o !== gprModel[2]) begin bad++; $display("[TB] FAIL bubble_fwd got=%b/%h want=0/%h", wb_valid_o, rd_data_a_o, gprModel[2]); end
        @(posedge clk); #1;
        e = expQ.pop_front();
        total++; if (retired_o !== e.retired || addr_err_o !== e.err) begin bad++; $display("[TB] FAIL bubble_count got=%h/%b want=%h/%b", retired_o, addr_err_o, e.retired, e.err); end
        idle();
        #1;
        total++; if (rd_data_a_o !== gprModel[2]) begin bad++; $display("[TB] FAIL bubble_store got=%h want=%h", rd_data_a_o, gprModel[2]); end
    endtask

    // Private-bank write to SP, then an out-of-range GPR write that must set the sticky flag
    task automatic test_private_illegal();
        exp_t e;
        drive_slot(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0100, 16'h0000);
        priv_rd_addr_i = 2'd0;
        #1;
        total++; if (priv_rd_data_o !== 16'h0100 || wb_priv_o !== 1'b1) begin bad++; $display("[TB] FAIL priv_bypass got=%h/%b want=0100/1", priv_rd_data_o, wb_priv_o); end
        @(posedge clk); #1;
        e = expQ.pop_front();
        idle();
        #1;
        total++; if (priv_rd_data_o !== privModel[0]) begin bad++; $display("[TB] FAIL priv_store got=%h want=%h", priv_rd_data_o, privModel[0]); end
        drive_slot(1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 16'h5555, 16'h0000);
        rd_addr_a_i = 3'd1;
        #1;
        total++; if (wb_valid_o !== 1'b0 || rd_data_a_o !== gprModel[1]) begin bad++; $display("[TB] FAIL illegal_fwd got=%b/%h want=0/%h", wb_valid_o, rd_data_a_o, gprModel[1]); end
        @(posedge clk); #1;
        e = expQ.pop_front();
        total++; if (addr_err_o !== e.err || retired_o !== e.retired) begin bad++; $display("[TB] FAIL illegal_flag got=%b/%h want=%b/%h", addr_err_o, retired_o, e.err, e.retired); end
        drive_slot(1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 16'h0A0A, 16'h0000);
        @(posedge clk); #1;
        e = expQ.pop_front();
        idle();
        priv_rd_addr_i = 2'd3;
        #1;
        total++; if (addr_err_o !== e.err || priv_rd_data_o !== privModel[3] || rd_data_a_o !== gprModel[1]) begin bad++; $display("[TB] FAIL illegal_sticky got=%b/%h/%h want=%b/%h/%h", addr_err_o, priv_rd_data_o, rd_data_a_o, e.err, privModel[3], gprModel[1]); end
    endtask

    // Asynchronous reset landing between edges while a write is pending
    task automatic test_async_reset();
        drive_slot(1'b1, 1'b0, 1'b0, 1'b0, 4'h6, 16'h7777, 16'h0000);
        rd_addr_a_i = 3'd3; rd_addr_b_i = 3'd6; priv_rd_addr_i = 2'd0;
        #2 rst = 1'b1;
        reset_model();
        #1;
        total++; if (priv_rd_data_o !== privModel[0] || rd_data_a_o !== gprModel[3]) begin bad++; $display("[TB] FAIL async_regs got=%h/%h want=%h/%h", priv_rd_data_o, rd_data_a_o, privModel[0], gprModel[3]); end
        total++; if (retired_o !== retModel || addr_err_o !== errModel || wb_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL async_state got=%h/%b/%b want=%h/%b/0", retired_o, addr_err_o, wb_valid_o, retModel, errModel); end
        @(posedge clk);
        @(negedge clk);
        reg_write_i = 1'b0; bubble_i = 1'b1;
        rst = 1'b0;
        #1;
        total++; if (rd_data_b_o !== gprModel[6] || retired_o !== retModel) begin bad++; $display("[TB] FAIL async_dropped got=%h/%h want=%h/%h", rd_data_b_o, retired_o, gprModel[6], retModel); end
    endtask

    // 65536 non-bubble, non-writing slots: counter passes FFFF and wraps back
    task automatic test_counter_wrap();
        exp_t e;
        for (int i = 0; i < 65536; i++) begin
            drive_slot(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
            @(posedge clk); #1;
            e = expQ.pop_front();
            if (i >= 65534) begin
                total++;
                if (retired_o !== e.retired) begin bad++; $display("[TB] FAIL wrap_retired slot=%0d got=%h want=%h", i, retired_o, e.retired); end
            end
        end
        idle();
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_write();
        test_bypass();
        test_bubble();
        test_private_illegal();
        test_async_reset();
        test_counter_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_regfile_stage.md
Name: wb_regfile_stage

Overview:
- Write-back stage of the 16-bit pipelined RISC core; sits directly downstream of the MEM/WB pipeline buffer and consumes its outputs.
- Selects the write-back value (ALU result vs memory data).
- Commits it to the general-purpose register bank or the private (special) register bank.
- Provides write-first read ports to decode, exports current-cycle write info for forwarding, and keeps a retired-instruction counter.

Parameters:
- DATA_W, 16, datapath width.
- NUM_GPR, 8, general-purpose registers, indexed by addr[2:0].
- NUM_PRIV, 4, private registers, indexed by addr[1:0]; index 0 is SP.
- SP_RESET, 16'h0FFF, SP value after reset.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  reset.
- reg_write_i  in  1  write enable from MEM/WB buffer.
- mem_or_reg_i  in  1  1 = write mem_data_i, 0 = write data_res_i.
- dest_or_private_i  in  1  0 = GPR bank, 1 = private bank.
- bubble_i  in  1  current MEM/WB slot is a bubble.
- dest_addr_i  in  4  destination register address.
- data_res_i  in  16  ALU/result data.
- mem_data_i  in  16  memory load data.
- rd_addr_a_i, rd_addr_b_i  in  3  GPR read addresses.
- rd_data_a_o, rd_data_b_o  out  16  GPR read data.
- priv_rd_addr_i  in  2  private read address.
- priv_rd_data_o  out  16  private read data.
- wb_valid_o  out  1  a legal write commits at the next posedge (forwarding).
- wb_priv_o  out  1  that write targets the private bank.
- wb_addr_o  out  4  that write's address.
- wb_data_o  out  16  that write's data.
- retired_o  out  16  retired-instruction count.
- addr_err_o  out  1  sticky illegal-address flag.

Behaviour:
- Reset: clk as named; rst is asynchronous and active-high.
  - On assertion: all GPRs = 0; private regs = 0 except SP = SP_RESET; retired_o = 0; addr_err_o = 0.
  - While rst = 1: wb_valid_o forced 0, and no writes or counts occur.
  - Reset mid-operation discards any write pending at the next edge.
- Write data: wb_data_o = mem_or_reg_i ? mem_data_i : data_res_i. This path is combinational.
- Legality:
  - GPR write is legal iff dest_addr_i[3] = 0.
  - Private write is legal iff dest_addr_i[3:2] = 0.
- Commit: we = reg_write_i & ~bubble_i & legal & ~rst. wb_valid_o = we.
  - The selected register is written at posedge clk.
  - Write latency is 1 edge; the value is visible in the register on the following cycle.
- Illegal write: reg_write_i & ~bubble_i & ~legal drops the write. addr_err_o is set at that posedge and is cleared only by rst.
- Reads are combinational and write-first:
  - If we, the bank matches, and the read index matches the write index, the output returns wb_data_o.
  - Otherwise the output returns the stored value.
  - Both GPR ports may hit the same register simultaneously.
- No hardwired zero register: R0 is writable.
- Retire counter:
  - Increments by 1 at posedge when ~bubble_i & reg_write_i, or when ~bubble_i & ~reg_write_i, i.e. every non-bubble slot. Illegal-address slots also count.
  - Wraps from 16'hFFFF to 16'h0000.
- Bubble with reg_write_i = 1: no write, no count, no error.
- Inputs change on negedge (upstream buffer); this stage samples them only at posedge.

Decomposition:
- Shared package holds: DATA_W, GPR/PRIV index widths, NUM_GPR, NUM_PRIV, SP_IDX = 0, SP_RESET, and the bank-select encoding (BANK_GPR = 0, BANK_PRIV = 1).
- One sub-module, reg_bank, is natural:
  - Parameterised depth and per-entry reset value.
  - Async-reset storage, one write port, N write-first read ports.
  - Instantiated twice: GPR bank with 2 read ports, private bank with 1 read port.

Test Plan:
- Reset then write: assert rst, release, then reg_write = 1, mem_or_reg = 0, dest = 4'h3, data_res = 16'hBEEF, bubble = 0 -> after the edge, rd_addr_a = 3 reads 16'hBEEF; retired_o = 1.
- Mux and bypass: mem_or_reg = 1, mem_data = 16'h1234, dest = 5, with rd_addr_a = rd_addr_b = 5 in the same cycle -> both reads = 16'h1234 before the edge; wb_valid_o = 1, wb_addr_o = 5.
- Bubble: bubble = 1, reg_write = 1, dest = 2, data = 16'hFFFF -> R2 unchanged, wb_valid_o = 0, retired_o unchanged.
- Private/illegal:
  - dest_or_private = 1, dest = 0, data = 16'h0100 -> priv_rd_addr = 0 reads 16'h0100.
  - Then dest = 4'h9 with dest_or_private = 0 -> no write, addr_err_o = 1 and stays 1; retired_o increments.
- Counter wrap: drive 65536 non-bubble slots -> retired_o returns to 16'h0000.
- Async reset mid-write: assert rst between edges while we = 1 -> immediately SP = 16'h0FFF, GPRs = 0, retired_o = 0, addr_err_o = 0; no write at the next edge.
